// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the 1:4 TDM demultiplexer.
// Optional shadow-bank build: TDM_DEMUX_DOUBLE_BUF_EN.
package tdm_demux_pkg;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // One-hot channel strobe for a channel index.
    function automatic logic [NCH-1:0] onehot(input logic [CH_W-1:0] sel);
        logic [NCH-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_1x4_reg.sv
// Four WIDTH-bit channel registers with indexed write, parallel load
// and a registered per-channel update strobe.
import tdm_demux_pkg::*;

module demux_1x4_reg #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH_W-1:0]      sel,
    input  logic                 we,
    input  logic [WIDTH-1:0]     din,
    input  logic                 load,
    input  logic [NCH*WIDTH-1:0] load_data,
    output logic [NCH*WIDTH-1:0] q,
    output logic [NCH-1:0]       strobe
);

    logic [WIDTH-1:0] bank [NCH];

    // Parallel load wins over a single-channel write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                bank[k] <= '0;
            end
            strobe <= '0;
        end else if (load) begin
            for (int k = 0; k < NCH; k++) begin
                bank[k] <= load_data[k*WIDTH +: WIDTH];
            end
            strobe <= '1;
        end else if (we) begin
            bank[sel] <= din;
            strobe    <= onehot(sel);
        end else begin
            strobe <= '0;
        end
    end

    // Flatten the bank so channel k sits at bits [k*WIDTH +: WIDTH].
    always_comb begin
        q = '0;
        for (int k = 0; k < NCH; k++) begin
            q[k*WIDTH +: WIDTH] = bank[k];
        end
    end

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demultiplexer: frame alignment, flywheel, resync, error pulse.
// Optional shadow bank (whole-frame dout update): TDM_DEMUX_DOUBLE_BUF_EN.
import tdm_demux_pkg::*;

module tdm_demux_1x4 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [NCH*WIDTH-1:0] dout,
    output logic [NCH-1:0]       ch_valid,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic                 locked
);

    state_t            state;
    state_t            state_n;
    logic [CH_W-1:0]   cnt;
    logic [CH_W-1:0]   cnt_n;
    logic              wr_en;
    logic [CH_W-1:0]   wr_sel;
    logic              done_n;
    logic              err_n;

    // State, channel counter and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HUNT;
            cnt        <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            frame_done <= done_n;
            sync_err   <= err_n;
        end
    end

    // Next state, write select and pulse requests.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_en   = 1'b0;
        wr_sel  = '0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            ST_HUNT: begin
                if (din_valid && frame_sync) begin
                    wr_en   = 1'b1;
                    cnt_n   = CH_W'(1);
                    state_n = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (din_valid) begin
                    wr_en = 1'b1;
                    if (frame_sync) begin
                        // Sync always restarts the frame at channel 0.
                        wr_sel = '0;
                        cnt_n  = CH_W'(1);
                        err_n  = (cnt != '0);
                    end else begin
                        wr_sel = cnt;
                        cnt_n  = cnt + 1'b1;
                        done_n = (cnt == CH_W'(NCH - 1));
                    end
                end
            end
            default: begin
                state_n = ST_HUNT;
            end
        endcase
    end

    assign locked = (state == ST_LOCKED);

`ifdef TDM_DEMUX_DOUBLE_BUF_EN

    logic [NCH*WIDTH-1:0] shadow_q;
    logic [NCH-1:0]       shadow_strobe;
    logic [NCH*WIDTH-1:0] frame_data;

    // The channel 3 sample joins the shadow contents on the final write.
    always_comb begin
        frame_data = shadow_q;
        frame_data[(NCH-1)*WIDTH +: WIDTH] = din;
    end

    demux_1x4_reg #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .sel       (wr_sel),
        .we        (wr_en),
        .din       (din),
        .load      (1'b0),
        .load_data ('0),
        .q         (shadow_q),
        .strobe    (shadow_strobe)
    );

    demux_1x4_reg #(
        .WIDTH (WIDTH)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .sel       (wr_sel),
        .we        (1'b0),
        .din       (din),
        .load      (done_n),
        .load_data (frame_data),
        .q         (dout),
        .strobe    (ch_valid)
    );

`else

    demux_1x4_reg #(
        .WIDTH (WIDTH)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .sel       (wr_sel),
        .we        (wr_en),
        .din       (din),
        .load      (1'b0),
        .load_data ('0),
        .q         (dout),
        .strobe    (ch_valid)
    );

`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed vector bench for tdm_demux_1x4 (WIDTH=4).
// Expectations follow the TDM_DEMUX_DOUBLE_BUF_EN setting of the build.
module tb_tdm_demux_1x4;

    localparam int W = 4;

    typedef struct {
        logic          rst;
        logic          vld;
        logic          fs;
        logic [W-1:0]  din;
        logic [15:0]   dout;
        logic [3:0]    chv;
        logic          done;
        logic          err;
        logic          lock;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  din;
    logic          din_valid;
    logic          frame_sync;
    logic [15:0]   dout;
    logic [3:0]    ch_valid;
    logic          frame_done;
    logic          sync_err;
    logic          locked;

    int n_vec = 0;
    int n_bad = 0;

    vec_t vecs[$];

    tdm_demux_1x4 #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    function automatic void add(
        input logic r, input logic v, input logic f, input logic [W-1:0] d,
        input logic [15:0] eo, input logic [3:0] ec,
        input logic ed, input logic ee, input logic el
    );
        vec_t t;
        t.rst = r; t.vld = v; t.fs = f; t.din = d;
        t.dout = eo; t.chv = ec; t.done = ed; t.err = ee; t.lock = el;
        vecs.push_back(t);
    endfunction

    task automatic apply(input vec_t t, input string name);
        rst        = t.rst;
        din_valid  = t.vld;
        frame_sync = t.fs;
        din        = t.din;
        @(posedge clk);
        #1;
        n_vec++;
        if (dout !== t.dout || ch_valid !== t.chv ||
            frame_done !== t.done || sync_err !== t.err ||
            locked !== t.lock) begin
            n_bad++;
            $display("FAIL %s: got dout=%h chv=%b done=%b err=%b lock=%b, exp dout=%h chv=%b done=%b err=%b lock=%b",
                     name, dout, ch_valid, frame_done, sync_err, locked,
                     t.dout, t.chv, t.done, t.err, t.lock);
        end
    endtask

    initial begin
        vec_t t;
        rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;

        //   rst  vld  fs   din    dout      chv      done err  lock
        add(1'b1,1'b0,1'b0,4'h0, 16'h0000,4'b0000,1'b0,1'b0,1'b0);
`ifndef TDM_DEMUX_DOUBLE_BUF_EN
        // HUNT drops everything without sync, and sync without valid.
        add(1'b0,1'b1,1'b0,4'hA, 16'h0000,4'b0000,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,4'hB, 16'h0000,4'b0000,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,4'hC, 16'h0000,4'b0000,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,4'hD, 16'h0000,4'b0000,1'b0,1'b0,1'b0);
        add(1'b0,1'b0,1'b1,4'h5, 16'h0000,4'b0000,1'b0,1'b0,1'b0);
        // First frame 1..4.
        add(1'b0,1'b1,1'b1,4'h1, 16'h0001,4'b0001,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h2, 16'h0021,4'b0010,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h3, 16'h0321,4'b0100,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h4, 16'h4321,4'b1000,1'b1,1'b0,1'b1);
        // Flywheel frame with a 3-cycle stall (sync during stall ignored).
        add(1'b0,1'b1,1'b0,4'h5, 16'h4325,4'b0001,1'b0,1'b0,1'b1);
        add(1'b0,1'b0,1'b0,4'hF, 16'h4325,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b0,1'b1,4'hF, 16'h4325,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b0,1'b0,4'hF, 16'h4325,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h6, 16'h4365,4'b0010,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h7, 16'h4765,4'b0100,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h8, 16'h8765,4'b1000,1'b1,1'b0,1'b1);
        // Misaligned sync after two channels.
        add(1'b0,1'b1,1'b0,4'h9, 16'h8769,4'b0001,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'hA, 16'h87A9,4'b0010,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b1,4'hF, 16'h87AF,4'b0001,1'b0,1'b1,1'b1);
        add(1'b0,1'b1,1'b0,4'h1, 16'h871F,4'b0010,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h2, 16'h821F,4'b0100,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h3, 16'h321F,4'b1000,1'b1,1'b0,1'b1);
        // Aligned sync at channel 0 is not an error.
        add(1'b0,1'b1,1'b1,4'h4, 16'h3214,4'b0001,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h5, 16'h3254,4'b0010,1'b0,1'b0,1'b1);
        // Reset mid-frame, then a fresh frame.
        add(1'b1,1'b1,1'b0,4'h6, 16'h0000,4'b0000,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,4'h7, 16'h0000,4'b0000,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,4'h1, 16'h0001,4'b0001,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h2, 16'h0021,4'b0010,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h3, 16'h0321,4'b0100,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h4, 16'h4321,4'b1000,1'b1,1'b0,1'b1);
`else
        add(1'b0,1'b1,1'b0,4'hA, 16'h0000,4'b0000,1'b0,1'b0,1'b0);
        // Frame 1..4 reaches dout only on the last write.
        add(1'b0,1'b1,1'b1,4'h1, 16'h0000,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h2, 16'h0000,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b0,1'b0,4'hE, 16'h0000,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h3, 16'h0000,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h4, 16'h4321,4'b1111,1'b1,1'b0,1'b1);
        // Frame cut at channel 2 by sync never reaches dout.
        add(1'b0,1'b1,1'b1,4'h5, 16'h4321,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h6, 16'h4321,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b1,4'hF, 16'h4321,4'b0000,1'b0,1'b1,1'b1);
        add(1'b0,1'b1,1'b0,4'h7, 16'h4321,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h8, 16'h4321,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h9, 16'h987F,4'b1111,1'b1,1'b0,1'b1);
        // Reset clears dout and the shadow bank.
        add(1'b0,1'b1,1'b0,4'h1, 16'h987F,4'b0000,1'b0,1'b0,1'b1);
        add(1'b1,1'b1,1'b0,4'h2, 16'h0000,4'b0000,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,4'h1, 16'h0000,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h2, 16'h0000,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h3, 16'h0000,4'b0000,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,4'h4, 16'h4321,4'b1111,1'b1,1'b0,1'b1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Long stall while locked: everything holds, no pulses.
        for (int i = 0; i < 8; i++) begin
            t.rst = 1'b0; t.vld = 1'b0; t.fs = i[0]; t.din = 4'(i);
            t.dout = 16'h4321; t.chv = 4'b0000;
            t.done = 1'b0; t.err = 1'b0; t.lock = 1'b1;
            apply(t, $sformatf("stall%0d", i));
        end

        // Wrap past channel 3 without sync keeps the flywheel going.
        t.rst = 1'b0; t.vld = 1'b1; t.fs = 1'b0; t.din = 4'hC;
`ifndef TDM_DEMUX_DOUBLE_BUF_EN
        t.dout = 16'h432C; t.chv = 4'b0001;
`else
        t.dout = 16'h4321; t.chv = 4'b0000;
`endif
        t.done = 1'b0; t.err = 1'b0; t.lock = 1'b1;
        apply(t, "wrap_ch0");

        // Sync during HUNT after reset while din_valid low is ignored.
        t.rst = 1'b1; t.vld = 1'b0; t.fs = 1'b0; t.din = 4'h0;
        t.dout = 16'h0000; t.chv = 4'b0000; t.lock = 1'b0;
        apply(t, "reset2");
        t.rst = 1'b0; t.fs = 1'b1;
        apply(t, "hunt_novalid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receive-side counterpart of the team's 4:1 channel multiplexer.
- Takes a time-division-multiplexed sample stream (channel 0 marked by frame_sync) and distributes the samples into four registered channel outputs.
- Sits after the TDM link, before per-channel consumers.
- Handles frame alignment, stalls, mid-frame resync and error reporting.

Parameters:
- WIDTH, 1, bits per sample/channel.
- NCH is fixed at 4 (package constant); not a parameter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  incoming TDM sample.
- din_valid  input  1  din valid this cycle; low = stall, no channel advance.
- frame_sync  input  1  qualified by din_valid; marks the current sample as channel 0.
- dout  output  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH], registered.
- ch_valid  output  4  one-cycle pulse per channel when its dout slice updates.
- frame_done  output  1  one-cycle pulse when the channel 3 sample of a complete frame is written.
- sync_err  output  1  one-cycle pulse on misaligned frame_sync.
- locked  output  1  high while in LOCKED.

Behaviour:
- Reset (rst=1 at clk edge): state=HUNT, ch_cnt=0, dout=0, ch_valid=0, frame_done=0, sync_err=0, locked=0. A reset mid-frame discards the partial frame; dout is cleared.
- Accepted sample: din_valid=1 in the relevant state.
  - All outputs update on the clock edge after acceptance, i.e. 1-cycle latency.
  - Pulses are high for exactly one cycle.
- HUNT:
  - din_valid && frame_sync: write din to channel 0, ch_cnt<=1, go to LOCKED.
  - All other samples are dropped with no output activity.
  - frame_sync without din_valid is ignored.
- LOCKED, din_valid=1, frame_sync=0:
  - Write channel ch_cnt and increment ch_cnt (2-bit, 3 wraps to 0).
  - Writing channel 3 also pulses frame_done.
  - Flywheel: frame_sync is not required at each channel 0.
- LOCKED, din_valid=1, frame_sync=1, ch_cnt==0: normal channel-0 write.
- LOCKED, din_valid=1, frame_sync=1, ch_cnt!=0:
  - Pulse sync_err, write channel 0, ch_cnt<=1, stay LOCKED.
  - Already-written channels of the partial frame keep their values.
  - No frame_done for the partial frame.
- LOCKED, din_valid=0: full hold. ch_cnt, dout and state are unchanged; pulses are 0.
- locked = (state==LOCKED). There is no path from LOCKED back to HUNT except rst.
- ch_valid[k] is asserted in the same cycle that dout slice k changes. At most one bit is set per cycle (non-double-buffered mode).

Optional Feature:
- Macro: TDM_DEMUX_DOUBLE_BUF_EN.
- Defined:
  - Samples land in an internal shadow register bank.
  - dout is loaded from the shadow bank (all 4 slices at once) only on frame completion (channel 3 write). That load happens in the same cycle frame_done pulses, with ch_valid=4'b1111.
  - Frames cut by sync_err or rst never reach dout.
  - Shadow bank resets to 0.
- Undefined: per-channel immediate update as specified above; no shadow bank is instantiated.

Decomposition:
- Package/header tdm_demux_pkg:
  - NCH=4.
  - CH_W=2.
  - State encoding ST_HUNT=1'b0, ST_LOCKED=1'b1.
- Natural sub-module: demux_1x4_reg.
  - Inputs: 2-bit select, write enable, WIDTH data.
  - Holds four WIDTH-bit registers and produces the one-hot write strobe (used for ch_valid).
  - Instantiated once for dout, plus once for the shadow bank when TDM_DEMUX_DOUBLE_BUF_EN is defined.
- Top contains the FSM, ch_cnt, sync checking and pulse generation.

Test Plan (WIDTH=4):
- Reset then samples A,B,C,D with din_valid=1, no frame_sync -> locked=0, dout=0, no pulses (HUNT drops all).
- Sync on 1, then 2,3,4 back-to-back -> dout=16'h4321 after 4 cycles; ch_valid 0001,0010,0100,1000; frame_done pulses with the last write; locked=1.
- Locked; send 5, stall din_valid=0 for 3 cycles, then 6,7,8 -> no change during the stall; final dout=16'h8765 with a single frame_done.
- Locked; send 9 (ch0), A (ch1), then F with frame_sync -> sync_err pulse; dout[3:0]=F, dout[7:4]=A; no frame_done; next samples go to ch1.
- Assert rst after 2 samples of a frame -> next cycle dout=0, locked=0, HUNT; a following sync frame 1..4 gives dout=16'h4321.
- TDM_DEMUX_DOUBLE_BUF_EN: frame 1..4 -> dout stays 0 until the 4th write, then 16'h4321 with ch_valid=1111. A frame cut at ch2 by sync_err leaves dout=16'h4321.
